// File: rtl/nco_sched.sv
// nco_sched: time-multiplexed LFO controller sharing one cosine LUT across
// NUM_CH phase channels. Each tick runs one sweep: one LUT request per channel
// slot, then a drain while the last results return.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   tick            sample strobe, starts a sweep when idle
//   en, freq        per-channel enable and frequency word
//   lut_phi         registered phase to the shared LUT
//   lut_wav         LUT sample, LUT_LAT cycles after its lut_phi
//   wav, wav_vld    per-channel held sample and one-cycle update strobe
//   busy, done      sweep in progress / last cycle of sweep
//   tick_miss       tick arrived while busy
module nco_sched #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned WIDTH      = 24,
   parameter int unsigned DEPTH      = 512,
   parameter int unsigned FREQ_WIDTH = 8,
   parameter int unsigned LUT_LAT    = 1,
   localparam int unsigned PHI_WIDTH = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick,
   input  logic [NUM_CH-1:0]          en,
   input  logic [NUM_CH*FREQ_WIDTH-1:0] freq,
   output logic [PHI_WIDTH-1:0]       lut_phi,
   input  logic [WIDTH-1:0]           lut_wav,
   output logic [NUM_CH*WIDTH-1:0]    wav,
   output logic [NUM_CH-1:0]          wav_vld,
   output logic                       busy,
   output logic                       done,
   output logic                       tick_miss
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SWEEP = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned SLOT_MAX = (NUM_CH > LUT_LAT + 1) ? NUM_CH : LUT_LAT + 1;
   localparam int unsigned SLOT_W   = $clog2(SLOT_MAX + 1);

   logic [1:0]            state, state_nx;
   logic [SLOT_W-1:0]     slot, slot_nx;
   logic [CH_W-1:0]       ch_cur, ch_nxt;
   logic                  slot_en;

   logic [PHI_WIDTH-1:0]  phi    [NUM_CH];
   logic [FREQ_WIDTH-1:0] cnt    [NUM_CH];
   logic [FREQ_WIDTH-1:0] freq_r [NUM_CH];
   logic [FREQ_WIDTH-1:0] freq_a [NUM_CH];
   logic [WIDTH-1:0]      wav_r  [NUM_CH];

   logic [LUT_LAT-1:0]    pipe_vld;
   logic [CH_W-1:0]       pipe_ch [LUT_LAT];

   // Bus packing / unpacking
   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign freq_a[g]                 = freq[g*FREQ_WIDTH +: FREQ_WIDTH];
      assign wav[g*WIDTH +: WIDTH]     = wav_r[g];
   end

   assign ch_cur = CH_W'(slot);
   assign ch_nxt = CH_W'(slot_nx);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         slot  <= '0;
      end else begin
         state <= state_nx;
         slot  <= slot_nx;
      end
   end

   // Next-state: slot counter walks channels in SWEEP, then LUT_LAT+1 drain cycles
   always_comb begin
      state_nx = state;
      slot_nx  = slot;
      case (state)
         S_IDLE: begin
            if (tick) begin
               state_nx = S_SWEEP;
               slot_nx  = '0;
            end
         end
         S_SWEEP: begin
            if (slot == SLOT_W'(NUM_CH - 1)) begin
               state_nx = S_DRAIN;
               slot_nx  = '0;
            end else begin
               slot_nx = slot + SLOT_W'(1);
            end
         end
         S_DRAIN: begin
            if (slot == SLOT_W'(LUT_LAT)) begin
               state_nx = S_IDLE;
               slot_nx  = '0;
            end else begin
               slot_nx = slot + SLOT_W'(1);
            end
         end
         default: begin
            state_nx = S_IDLE;
            slot_nx  = '0;
         end
      endcase
   end

   // Datapath: slot open/close, channel accumulators, capture pipeline
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lut_phi   <= '0;
         slot_en   <= 1'b0;
         wav_vld   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         tick_miss <= 1'b0;
         pipe_vld  <= '0;
         for (int i = 0; i < int'(LUT_LAT); i++) pipe_ch[i] <= '0;
         for (int i = 0; i < int'(NUM_CH); i++) begin
            phi[i]    <= '0;
            cnt[i]    <= '0;
            freq_r[i] <= '0;
            wav_r[i]  <= '0;
         end
      end else begin
         wav_vld   <= '0;
         tick_miss <= tick && (state != S_IDLE);
         busy      <= (state_nx != S_IDLE);
         done      <= (state_nx == S_DRAIN) && (slot_nx == SLOT_W'(LUT_LAT));

         // Opening a slot: en for that channel is latched here and governs the whole slot
         if (state_nx == S_SWEEP) begin
            slot_en <= en[ch_nxt];
            lut_phi <= en[ch_nxt] ? phi[ch_nxt] : '0;
         end

         // Closing a slot: advance or clear the channel's divider/phase
         if (state == S_SWEEP) begin
            if (slot_en) begin
               if (cnt[ch_cur] == freq_r[ch_cur]) begin
                  cnt[ch_cur]    <= '0;
                  freq_r[ch_cur] <= ~freq_a[ch_cur];
                  phi[ch_cur]    <= (phi[ch_cur] == PHI_WIDTH'(DEPTH - 1)) ? '0
                                    : phi[ch_cur] + PHI_WIDTH'(1);
               end else begin
                  cnt[ch_cur] <= cnt[ch_cur] + FREQ_WIDTH'(1);
               end
            end else begin
               cnt[ch_cur]    <= '0;
               freq_r[ch_cur] <= '0;
               phi[ch_cur]    <= '0;
            end
         end

         // Request tag pipeline: stage LUT_LAT-1 lines up with the returning lut_wav
         pipe_vld[0] <= (state == S_SWEEP) && slot_en;
         pipe_ch[0]  <= ch_cur;
         for (int i = 1; i < int'(LUT_LAT); i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_ch[i]  <= pipe_ch[i-1];
         end

         if (pipe_vld[LUT_LAT-1]) begin
            wav_r[pipe_ch[LUT_LAT-1]]   <= lut_wav;
            wav_vld[pipe_ch[LUT_LAT-1]] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nco_sched.sv
// tb_nco_sched: self-checking bench for nco_sched (NUM_CH=4, LUT_LAT=1).
// A behavioural LUT answers lut_phi one cycle later; a per-channel model
// (phase plus sweeps-until-next-step countdown) predicts phases and samples.
module tb_nco_sched;

   localparam int NC  = 4;
   localparam int DEP = 512;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tick = 1'b0;
   logic [3:0]  en = '0;
   logic [31:0] freq = '0;
   logic [8:0]  lut_phi;
   logic [23:0] lut_wav = '0;
   logic [95:0] wav;
   logic [3:0]  wav_vld;
   logic        busy, done, tick_miss;

   int total = 0;
   int bad   = 0;

   int          m_phi  [NC];
   int          m_wait [NC];
   logic [23:0] m_wav  [NC];
   int          s_phi  [NC];
   logic [3:0]  s_en;

   logic [8:0]  o_phi  [12];
   logic [3:0]  o_vld  [12];
   logic        o_busy [12];
   logic        o_done [12];
   logic        o_miss [12];
   logic [23:0] o_wav  [NC];

   nco_sched dut (
      .clk(clk), .rst(rst), .tick(tick), .en(en), .freq(freq),
      .lut_phi(lut_phi), .lut_wav(lut_wav), .wav(wav), .wav_vld(wav_vld),
      .busy(busy), .done(done), .tick_miss(tick_miss)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] lut_fn(input logic [8:0] p);
      logic [31:0] x;
      x = {23'd0, p} * 32'd40503 + 32'd777;
      return 24'(x ^ (x << 7));
   endfunction

   // One-cycle-latency LUT
   always @(posedge clk) lut_wav <= lut_fn(lut_phi);

   task automatic model_clear();
      for (int k = 0; k < NC; k++) begin
         m_phi[k] = 0; m_wait[k] = 0; m_wav[k] = '0;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0; tick = 1'b0; en = '0; freq = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_clear();
   endtask

   // Tick at cycle 0, record cycles 0..11; extra ticks at cycles t1/t2
   task automatic do_sweep(input logic [3:0] en_v, input logic [31:0] fq, input int t1, input int t2);
      logic [7:0] f;
      for (int k = 0; k < NC; k++) s_phi[k] = en_v[k] ? m_phi[k] : 0;
      s_en = en_v;
      @(negedge clk);
      tick = 1'b1; en = en_v; freq = fq;
      for (int c = 0; c < 12; c++) begin
         o_phi[c] = lut_phi; o_vld[c] = wav_vld; o_busy[c] = busy;
         o_done[c] = done; o_miss[c] = tick_miss;
         @(negedge clk);
         tick = ((c + 1) == t1) || ((c + 1) == t2);
      end
      tick = 1'b0;
      for (int k = 0; k < NC; k++) o_wav[k] = wav[k*24 +: 24];
      for (int k = 0; k < NC; k++) begin
         f = fq[k*8 +: 8];
         if (en_v[k]) begin
            m_wav[k] = lut_fn(9'(m_phi[k]));
            if (m_wait[k] == 0) begin
               m_phi[k]  = (m_phi[k] + 1) % DEP;
               m_wait[k] = 255 - int'(f);
            end else begin
               m_wait[k] = m_wait[k] - 1;
            end
         end else begin
            m_phi[k] = 0; m_wait[k] = 0;
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (lut_phi !== 9'd0) begin bad++; $display("FAIL reset_lut_phi got=%0h want=0", lut_phi); end
      total++; if (wav !== 96'd0) begin bad++; $display("FAIL reset_wav got=%0h want=0", wav); end
      total++; if ({wav_vld, busy, done, tick_miss} !== 7'd0) begin
         bad++; $display("FAIL reset_flags got=%0b want=0", {wav_vld, busy, done, tick_miss});
      end
   endtask

   task automatic test_basic();
      logic [3:0] ev;
      apply_reset();
      do_sweep(4'hF, 32'hFFFF_FFFF, -1, -1);
      for (int c = 0; c < 12; c++) begin
         ev = (c >= 3 && c <= 6) ? (4'b0001 << (c - 3)) & s_en : 4'b0000;
         total++; if (o_vld[c] !== ev) begin bad++; $display("FAIL basic_vld c=%0d got=%0b want=%0b", c, o_vld[c], ev); end
         total++; if (o_busy[c] !== (c >= 1 && c <= 6)) begin bad++; $display("FAIL basic_busy c=%0d got=%0b", c, o_busy[c]); end
         total++; if (o_done[c] !== (c == 6)) begin bad++; $display("FAIL basic_done c=%0d got=%0b", c, o_done[c]); end
         if (c >= 1 && c <= 4) begin
            total++; if (o_phi[c] !== 9'd0) begin bad++; $display("FAIL basic_phi c=%0d got=%0h want=0", c, o_phi[c]); end
         end
      end
      for (int k = 0; k < NC; k++) begin
         total++; if (o_wav[k] !== m_wav[k]) begin bad++; $display("FAIL basic_wav k=%0d got=%0h want=%0h", k, o_wav[k], m_wav[k]); end
      end
   endtask

   task automatic test_period();
      logic [8:0] seq [8];
      seq = '{9'd0, 9'd1, 9'd1, 9'd1, 9'd2, 9'd2, 9'd2, 9'd3};
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         do_sweep(4'hF, 32'hFFFF_FFFD, -1, -1);
         total++; if (o_phi[1] !== seq[i]) begin bad++; $display("FAIL period_phi i=%0d got=%0d want=%0d", i, o_phi[1], seq[i]); end
      end
   endtask

   task automatic test_wrap();
      logic [8:0] ep;
      apply_reset();
      for (int i = 0; i < 513; i++) begin
         ep = 9'(i % DEP);
         do_sweep(4'hF, 32'hFFFF_FFFF, -1, -1);
         total++; if (o_phi[1] !== ep) begin bad++; $display("FAIL wrap_phi i=%0d got=%0d want=%0d", i, o_phi[1], ep); end
         total++; if (o_wav[0] !== lut_fn(ep)) begin bad++; $display("FAIL wrap_wav i=%0d got=%0h want=%0h", i, o_wav[0], lut_fn(ep)); end
      end
   endtask

   task automatic test_enable_mask();
      logic [3:0] ev;
      apply_reset();
      do_sweep(4'hF, 32'hFFFF_FFFF, -1, -1);
      do_sweep(4'hF, 32'hFFFF_FFFF, -1, -1);
      for (int n = 0; n < 2; n++) begin
         do_sweep(4'b0101, 32'hFFFF_FFFF, -1, -1);
         for (int c = 0; c < 12; c++) begin
            ev = (c >= 3 && c <= 6) ? (4'b0001 << (c - 3)) & 4'b0101 : 4'b0000;
            total++; if (o_vld[c] !== ev) begin bad++; $display("FAIL mask_vld c=%0d got=%0b want=%0b", c, o_vld[c], ev); end
            total++; if (o_done[c] !== (c == 6)) begin bad++; $display("FAIL mask_done c=%0d got=%0b", c, o_done[c]); end
         end
         for (int k = 0; k < NC; k++) begin
            total++; if (o_phi[k+1] !== 9'(s_phi[k])) begin bad++; $display("FAIL mask_phi k=%0d got=%0d want=%0d", k, o_phi[k+1], s_phi[k]); end
            total++; if (o_wav[k] !== m_wav[k]) begin bad++; $display("FAIL mask_wav k=%0d got=%0h want=%0h", k, o_wav[k], m_wav[k]); end
         end
      end
   endtask

   task automatic test_tick_miss();
      apply_reset();
      do_sweep(4'hF, 32'hFFFF_FFFF, 3, 6);
      for (int c = 0; c < 12; c++) begin
         total++; if (o_miss[c] !== (c == 4 || c == 7)) begin bad++; $display("FAIL miss_pulse c=%0d got=%0b", c, o_miss[c]); end
         total++; if (o_busy[c] !== (c >= 1 && c <= 6)) begin bad++; $display("FAIL miss_busy c=%0d got=%0b", c, o_busy[c]); end
         total++; if (o_done[c] !== (c == 6)) begin bad++; $display("FAIL miss_done c=%0d got=%0b", c, o_done[c]); end
      end
      for (int i = 0; i < 4; i++) begin
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL miss_extra_sweep i=%0d busy=%0b want=0", i, busy); end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      do_sweep(4'hF, 32'hFFFF_FFFF, -1, -1);
      do_sweep(4'hF, 32'hFFFF_FFFF, -1, -1);
      @(negedge clk); tick = 1'b1; en = 4'hF;
      @(negedge clk); tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      total++; if (lut_phi !== 9'd0) begin bad++; $display("FAIL midrst_phi got=%0h want=0", lut_phi); end
      total++; if (wav !== 96'd0) begin bad++; $display("FAIL midrst_wav got=%0h want=0", wav); end
      total++; if ({wav_vld, busy, done} !== 6'd0) begin bad++; $display("FAIL midrst_flags got=%0b want=0", {wav_vld, busy, done}); end
      @(negedge clk); rst = 1'b1;
      model_clear();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++; if ({wav_vld, done, busy} !== 6'd0) begin bad++; $display("FAIL midrst_after i=%0d got=%0b want=0", i, {wav_vld, done, busy}); end
      end
      do_sweep(4'hF, 32'hFFFF_FFFF, -1, -1);
      for (int k = 0; k < NC; k++) begin
         total++; if (o_phi[k+1] !== 9'd0) begin bad++; $display("FAIL midrst_restart_phi k=%0d got=%0d want=0", k, o_phi[k+1]); end
      end
      total++; if (o_done[6] !== 1'b1) begin bad++; $display("FAIL midrst_restart_done got=%0b want=1", o_done[6]); end
   endtask

   task automatic test_random();
      logic [3:0]  ev, rv;
      logic [31:0] fq;
      apply_reset();
      for (int n = 0; n < 40; n++) begin
         rv = 4'($urandom);
         for (int k = 0; k < NC; k++) fq[k*8 +: 8] = 8'hF8 | 8'($urandom_range(0, 7));
         do_sweep(rv, fq, -1, -1);
         for (int c = 0; c < 12; c++) begin
            ev = (c >= 3 && c <= 6) ? (4'b0001 << (c - 3)) & rv : 4'b0000;
            total++; if (o_vld[c] !== ev) begin bad++; $display("FAIL rand_vld n=%0d c=%0d got=%0b want=%0b", n, c, o_vld[c], ev); end
         end
         total++; if (o_done[6] !== 1'b1) begin bad++; $display("FAIL rand_done n=%0d got=%0b want=1", n, o_done[6]); end
         for (int k = 0; k < NC; k++) begin
            total++; if (o_phi[k+1] !== 9'(s_phi[k])) begin bad++; $display("FAIL rand_phi n=%0d k=%0d got=%0d want=%0d", n, k, o_phi[k+1], s_phi[k]); end
            total++; if (o_wav[k] !== m_wav[k]) begin bad++; $display("FAIL rand_wav n=%0d k=%0d got=%0h want=%0h", n, k, o_wav[k], m_wav[k]); end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_period();
      test_wrap();
      test_enable_mask();
      test_tick_miss();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
